// File: rtl/surf_cout_align_ctrl_if.sv
// PHY-side signal bundle for the COUT word-alignment controller.
// master: the controller (drives ISERDES/IDELAY control, reads COUT).
// slave:  the PHY (or a PHY model) on the other end.
interface surf_cout_align_ctrl_if;
    logic       sync_i;
    logic [3:0] cout_i;
    logic [5:0] idelay_current_i;
    logic       iserdes_rst_o;
    logic [5:0] idelay_value_o;
    logic       idelay_load_o;
    logic       bitslip_o;

    modport master (
        input  sync_i,
        input  cout_i,
        input  idelay_current_i,
        output iserdes_rst_o,
        output idelay_value_o,
        output idelay_load_o,
        output bitslip_o
    );

    modport slave (
        output sync_i,
        output cout_i,
        output idelay_current_i,
        input  iserdes_rst_o,
        input  idelay_value_o,
        input  idelay_load_o,
        input  bitslip_o
    );
endinterface

// File: rtl/surf_cout_align_ctrl.sv
// COUT alignment controller: resets the ISERDES, scans all 63 IDELAY taps for
// the widest run of taps that return any rotation of TRAIN_PATTERN, parks the
// delay at the centre of that eye, then bitslips until the nibble matches
// TRAIN_PATTERN exactly.
// Optional feature: define SURF_COUT_ALIGN_EYEMAP_EN to keep a per-tap good map
// on eye_map_o; without it eye_map_o is tied to zero.
module surf_cout_align_ctrl #(
    parameter logic [3:0]  TRAIN_PATTERN = 4'b1000,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned CHECK_CYCLES  = 64,
    parameter int unsigned MIN_EYE       = 4
) (
    input  logic                   sysclk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    surf_cout_align_ctrl_if.master phy,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   fail_o,
    output logic [5:0]             eye_start_o,
    output logic [6:0]             eye_width_o,
    output logic [2:0]             slip_count_o,
    output logic [62:0]            eye_map_o
);

    localparam int unsigned CW = $clog2(CHECK_CYCLES + SETTLE_CYCLES + 9);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_CYCLES - 1);
    localparam logic [CW-1:0] SYNC_LAST   = CW'(3);
    localparam logic [CW-1:0] SLIPW_LAST  = CW'(7);
    localparam logic [6:0]    MIN_EYE_W   = 7'(MIN_EYE);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RST     = 4'd1;
    localparam logic [3:0] S_SYNCW   = 4'd2;
    localparam logic [3:0] S_LOAD    = 4'd3;
    localparam logic [3:0] S_SETTLE  = 4'd4;
    localparam logic [3:0] S_CHECK   = 4'd5;
    localparam logic [3:0] S_NEXT    = 4'd6;
    localparam logic [3:0] S_CENTER  = 4'd7;
    localparam logic [3:0] S_CSETTLE = 4'd8;
    localparam logic [3:0] S_ALIGN   = 4'd9;
    localparam logic [3:0] S_SLIP    = 4'd10;
    localparam logic [3:0] S_SLIPW   = 4'd11;
    localparam logic [3:0] S_DONE    = 4'd12;
    localparam logic [3:0] S_FAIL    = 4'd13;

    localparam logic [3:0] ROT1 = {TRAIN_PATTERN[2:0], TRAIN_PATTERN[3]};
    localparam logic [3:0] ROT2 = {TRAIN_PATTERN[1:0], TRAIN_PATTERN[3:2]};
    localparam logic [3:0] ROT3 = {TRAIN_PATTERN[0], TRAIN_PATTERN[3:1]};

    // Linear tap to IDELAY encoding: encoded 31 and 32 are the same delay,
    // so taps from 32 upward skip over 32.
    function automatic logic [5:0] enc_tap(input logic [5:0] t);
        return t[5] ? t + 6'd1 : t;
    endfunction

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync_seen_q, sync_seen_d;
    logic [5:0]    tap_q, tap_d;
    logic          tap_good_q, tap_good_d;
    logic [5:0]    run_start_q, run_start_d;
    logic [6:0]    run_len_q, run_len_d;
    logic [5:0]    best_start_q, best_start_d;
    logic [6:0]    best_len_q, best_len_d;
    logic [2:0]    slip_q, slip_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic          iserdes_rst_q, iserdes_rst_d;
    logic          load_q, load_d;
    logic [5:0]    value_q, value_d;
    logic          bitslip_q, bitslip_d;
`ifdef SURF_COUT_ALIGN_EYEMAP_EN
    logic [62:0]   map_q, map_d;
`endif

    logic       rot_match;
    logic       exact_match;
    logic [5:0] center;
    logic       unused_idelay_current;

    assign rot_match   = (phy.cout_i == TRAIN_PATTERN) || (phy.cout_i == ROT1) ||
                         (phy.cout_i == ROT2) || (phy.cout_i == ROT3);
    assign exact_match = (phy.cout_i == TRAIN_PATTERN);
    // best_len_q never exceeds 63, so half of it always fits in 6 bits
    assign center      = best_start_q + 6'(best_len_q >> 1);
    assign unused_idelay_current = ^phy.idelay_current_i;

    // Next-state, tracker and registered-strobe computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sync_seen_d   = sync_seen_q;
        tap_d         = tap_q;
        tap_good_d    = tap_good_q;
        run_start_d   = run_start_q;
        run_len_d     = run_len_q;
        best_start_d  = best_start_q;
        best_len_d    = best_len_q;
        slip_d        = slip_q;
        done_d        = done_q;
        fail_d        = fail_q;
        value_d       = value_q;
        iserdes_rst_d = 1'b0;
        load_d        = 1'b0;
        bitslip_d     = 1'b0;
`ifdef SURF_COUT_ALIGN_EYEMAP_EN
        map_d         = map_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) begin
                    state_d      = S_RST;
                    cnt_d        = '0;
                    done_d       = 1'b0;
                    fail_d       = 1'b0;
                    tap_d        = '0;
                    run_start_d  = '0;
                    run_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    slip_d       = '0;
`ifdef SURF_COUT_ALIGN_EYEMAP_EN
                    map_d        = '0;
`endif
                end
            end
            S_RST: begin
                state_d     = S_SYNCW;
                sync_seen_d = 1'b0;
                cnt_d       = '0;
            end
            S_SYNCW: begin
                if (!sync_seen_q) begin
                    if (phy.sync_i) begin
                        sync_seen_d = 1'b1;
                        cnt_d       = '0;
                    end
                end else if (cnt_q == SYNC_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE, S_CSETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = (state_q == S_SETTLE) ? S_CHECK : S_ALIGN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CHECK: begin
                if (!rot_match) begin
                    tap_good_d = 1'b0;
                    state_d    = S_NEXT;
                end else if (cnt_q == CHECK_LAST) begin
                    tap_good_d = 1'b1;
                    state_d    = S_NEXT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_NEXT: begin
                if (tap_good_q) begin
                    if (run_len_q == '0) begin
                        run_start_d = tap_q;
                    end
                    run_len_d = run_len_q + 7'd1;
                end else begin
                    run_len_d = '0;
                end
                // A run is only scored when it closes (bad tap or last tap);
                // strict compare keeps the earlier eye on a tie.
                if (!tap_good_q && (run_len_q > best_len_q)) begin
                    best_len_d   = run_len_q;
                    best_start_d = run_start_q;
                end else if (tap_good_q && (tap_q == 6'd62) && (run_len_d > best_len_q)) begin
                    best_len_d   = run_len_d;
                    best_start_d = run_start_d;
                end
`ifdef SURF_COUT_ALIGN_EYEMAP_EN
                map_d[tap_q] = tap_good_q;
`endif
                if (tap_q == 6'd62) begin
                    state_d = S_CENTER;
                end else begin
                    tap_d   = tap_q + 6'd1;
                    state_d = S_LOAD;
                end
            end
            S_CENTER: begin
                if (best_len_q < MIN_EYE_W) begin
                    state_d = S_FAIL;
                    fail_d  = 1'b1;
                end else begin
                    state_d = S_CSETTLE;
                    cnt_d   = '0;
                    value_d = enc_tap(center);
                end
            end
            S_ALIGN: begin
                if (!exact_match) begin
                    if (slip_q == 3'd7) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = S_SLIP;
                        slip_d  = slip_q + 3'd1;
                    end
                end else if (cnt_q == CHECK_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SLIP: begin
                state_d = S_SLIPW;
                cnt_d   = '0;
            end
            S_SLIPW: begin
                if (cnt_q == SLIPW_LAST) begin
                    state_d = S_ALIGN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so each one is high for
        // exactly the cycle the FSM spends in the corresponding state.
        iserdes_rst_d = (state_d == S_RST);
        bitslip_d     = (state_d == S_SLIP);
        load_d        = (state_d == S_LOAD) || ((state_q == S_CENTER) && (state_d == S_CSETTLE));
        if (state_d == S_LOAD) begin
            value_d = enc_tap(tap_d);
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sync_seen_q   <= 1'b0;
            tap_q         <= '0;
            tap_good_q    <= 1'b0;
            run_start_q   <= '0;
            run_len_q     <= '0;
            best_start_q  <= '0;
            best_len_q    <= '0;
            slip_q        <= '0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            iserdes_rst_q <= 1'b0;
            load_q        <= 1'b0;
            value_q       <= '0;
            bitslip_q     <= 1'b0;
`ifdef SURF_COUT_ALIGN_EYEMAP_EN
            map_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync_seen_q   <= sync_seen_d;
            tap_q         <= tap_d;
            tap_good_q    <= tap_good_d;
            run_start_q   <= run_start_d;
            run_len_q     <= run_len_d;
            best_start_q  <= best_start_d;
            best_len_q    <= best_len_d;
            slip_q        <= slip_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            iserdes_rst_q <= iserdes_rst_d;
            load_q        <= load_d;
            value_q       <= value_d;
            bitslip_q     <= bitslip_d;
`ifdef SURF_COUT_ALIGN_EYEMAP_EN
            map_q         <= map_d;
`endif
        end
    end

    assign busy_o             = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
    assign done_o             = done_q;
    assign fail_o             = fail_q;
    assign eye_start_o        = best_start_q;
    assign eye_width_o        = best_len_q;
    assign slip_count_o       = slip_q;
    assign phy.iserdes_rst_o  = iserdes_rst_q;
    assign phy.idelay_load_o  = load_q;
    assign phy.idelay_value_o = value_q;
    assign phy.bitslip_o      = bitslip_q;
`ifdef SURF_COUT_ALIGN_EYEMAP_EN
    assign eye_map_o          = map_q;
`else
    assign eye_map_o          = '0;
`endif

endmodule
